// File: rtl/h_s_rca_pkg.sv
// Shared types and helpers for the RCA sum accumulator and its adder.
// Saturation limits support the optional H_S_RCA_SUM_ACC_SATURATE_EN build.
package h_s_rca_pkg;

  localparam int unsigned IN_W_DEF  = 13;
  localparam int unsigned ACC_W_DEF = 16;

  typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

  // The caller truncates the 64-bit result to its own accumulator width.
  function automatic logic signed [63:0] sext(input logic [63:0] v, input int unsigned w);
    return $signed(v << (64 - w)) >>> (64 - w);
  endfunction

  function automatic logic signed [63:0] sat_max(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/h_s_rca_sum_accumulator_if.sv
// Input sum stream and framed result stream for the sum accumulator.
// The master modport is the producer/consumer side; slave is the accumulator.
interface h_s_rca_sum_accumulator_if import h_s_rca_pkg::*; #(
  parameter int unsigned IN_W  = IN_W_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_sum;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  modport master (
    output in_valid, in_sum, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_sum, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_count, out_ovf
  );
endinterface

// File: rtl/h_s_acc_add_ovf.sv
// Signed ACC_W adder with overflow detect; clamps to the signed limits
// instead of wrapping when H_S_RCA_SUM_ACC_SATURATE_EN is defined.
module h_s_acc_add_ovf #(
  parameter int unsigned ACC_W = 16
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);
  logic [ACC_W-1:0] raw;

  assign raw = a + b;
  assign ovf = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);

`ifdef H_S_RCA_SUM_ACC_SATURATE_EN
  import h_s_rca_pkg::*;
  // On overflow both operands share a sign, so a's sign picks the limit.
  assign sum = ovf ? (a[ACC_W-1] ? ACC_W'(sat_min(ACC_W)) : ACC_W'(sat_max(ACC_W))) : raw;
`else
  assign sum = raw;
`endif

endmodule

// File: rtl/h_s_rca_sum_accumulator.sv
// Frames the 13-bit signed RCA sum stream into wide signed totals with beat count
// and sticky overflow. Optional clamping: define H_S_RCA_SUM_ACC_SATURATE_EN.
module h_s_rca_sum_accumulator import h_s_rca_pkg::*; #(
  parameter int unsigned IN_W    = IN_W_DEF,
  parameter int unsigned ACC_W   = ACC_W_DEF,
  parameter int unsigned MAX_CNT = 8,
  parameter int unsigned CNT_W   = $clog2(MAX_CNT + 1)
) (
  input logic                      clk,
  input logic                      rst,
  h_s_rca_sum_accumulator_if.slave bus
);
  state_e           state_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q;
  logic [ACC_W-1:0] out_acc_q;
  logic [CNT_W-1:0] out_count_q;
  logic             out_ovf_q;

  logic [ACC_W-1:0] beat;
  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;
  logic             xfer;
  logic             close;

  assign bus.in_ready  = (state_q != StHold);
  assign bus.out_valid = out_valid_q;
  assign bus.out_acc   = out_acc_q;
  assign bus.out_count = out_count_q;
  assign bus.out_ovf   = out_ovf_q;

  assign xfer = bus.in_valid && bus.in_ready;
  assign beat = ACC_W'(sext(64'(bus.in_sum), IN_W));

  h_s_acc_add_ovf #(
    .ACC_W (ACC_W)
  ) u_add (
    .a   (acc_q),
    .b   (beat),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  always_comb begin
    acc_d   = add_sum;
    count_d = count_q + CNT_W'(1);
    ovf_d   = ovf_q | add_ovf;
    // The first beat of a frame starts fresh rather than adding to stale state.
    if (state_q == StIdle) begin
      acc_d   = beat;
      count_d = CNT_W'(1);
      ovf_d   = 1'b0;
    end
    close = bus.in_last || (count_d == CNT_W'(MAX_CNT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StAccum: begin
          if (xfer) begin
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            if (close) begin
              state_q     <= StHold;
              out_valid_q <= 1'b1;
              out_acc_q   <= acc_d;
              out_count_q <= count_d;
              out_ovf_q   <= ovf_d;
            end else begin
              state_q <= StAccum;
            end
          end
        end
        StHold: begin
          if (out_valid_q && bus.out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
